// File: rtl/crc_pkg.sv
// Shared types and constants for the CRC scan path (sequencer now, calculator/compare later).
package crc_pkg;

   localparam int CRC_WAIT_W = 4;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      WAIT    = 3'd2,
      PROCESS = 3'd3,
      DONE    = 3'd4
   } crc_scan_state_t;

   // A scan is in flight while a word is being fetched, awaited or handed over.
   function automatic logic scan_active(crc_scan_state_t st);
      return (st == FETCH) || (st == WAIT) || (st == PROCESS);
   endfunction

endpackage

// File: rtl/crc_scan_ctrl_if.sv
// Control, memory-port and calculator-pacing signals of the CRC scan sequencer.
interface crc_scan_ctrl_if #(
   parameter int ADDR_W = 10
) ();

   logic              crc_start;
   logic              crc_abort;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W-1:0] end_addr;
   logic              crc_hold;
   logic [ADDR_W-1:0] mem_addr_out;
   logic              mem_rd_en;
   logic              crc_init;
   logic              crc_en;
   logic              crc_last;
   logic              crc_busy;
   logic              crc_rdy;
   logic              range_err;
   logic [ADDR_W:0]   word_cnt;

   modport master (
      output crc_start, crc_abort, start_addr, end_addr, crc_hold,
      input  mem_addr_out, mem_rd_en, crc_init, crc_en, crc_last,
             crc_busy, crc_rdy, range_err, word_cnt
   );

   modport slave (
      input  crc_start, crc_abort, start_addr, end_addr, crc_hold,
      output mem_addr_out, mem_rd_en, crc_init, crc_en, crc_last,
             crc_busy, crc_rdy, range_err, word_cnt
   );

endinterface

// File: rtl/crc_addr_cnt.sv
// Loadable scan address counter; latches the window end and flags the final word.
module crc_addr_cnt #(
   parameter int ADDR_W = 10
) (
   input  logic              clk50m,
   input  logic              rst_n,
   input  logic              load,
   input  logic              inc,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [ADDR_W-1:0] load_end,
   output logic [ADDR_W-1:0] addr,
   output logic              is_last
);

   logic [ADDR_W-1:0] addr_reg;
   logic [ADDR_W-1:0] end_reg;
   logic [ADDR_W-1:0] bit_eq;

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         addr_reg <= '0;
         end_reg  <= '0;
      end else if (load) begin
         addr_reg <= load_addr;
         end_reg  <= load_end;
      end else if (inc) begin
         addr_reg <= addr_reg + ADDR_W'(1);
      end
   end

   // Equality is the only end test, so a window ending at the top address never wraps.
   for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_eq
      assign bit_eq[gi] = ~(addr_reg[gi] ^ end_reg[gi]);
   end

   assign is_last = &bit_eq;
   assign addr    = addr_reg;

endmodule

// File: rtl/crc_scan_ctrl.sv
// Walks a programmable memory window and paces the CRC calculator one word at a time.
module crc_scan_ctrl
   import crc_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int MEM_LAT = 1
) (
   input  logic            clk50m,
   input  logic            rst_n,
   crc_scan_ctrl_if.slave  bus
);

   localparam logic [CRC_WAIT_W-1:0] WAIT_LOAD =
      (MEM_LAT > 0) ? CRC_WAIT_W'(MEM_LAT - 1) : '0;

   crc_scan_state_t         state_reg, state_next;
   logic [CRC_WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
   logic                    first_reg, first_next;
   logic                    range_err_reg, range_err_next;
   logic [ADDR_W:0]         word_cnt_reg, word_cnt_next;

   logic                    addr_load;
   logic                    addr_inc;
   logic                    is_last;
   logic [ADDR_W-1:0]       cur_addr;
   logic                    start_ok;
   logic                    consume;

   crc_addr_cnt #(
      .ADDR_W (ADDR_W)
   ) u_addr_cnt (
      .clk50m    (clk50m),
      .rst_n     (rst_n),
      .load      (addr_load),
      .inc       (addr_inc),
      .load_addr (bus.start_addr),
      .load_end  (bus.end_addr),
      .addr      (cur_addr),
      .is_last   (is_last)
   );

   assign start_ok = bus.crc_start && !bus.crc_abort;
   assign consume  = (state_reg == PROCESS) && !bus.crc_hold && !bus.crc_abort;

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         wait_cnt_reg  <= '0;
         first_reg     <= 1'b0;
         range_err_reg <= 1'b0;
         word_cnt_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         wait_cnt_reg  <= wait_cnt_next;
         first_reg     <= first_next;
         range_err_reg <= range_err_next;
         word_cnt_reg  <= word_cnt_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      wait_cnt_next  = wait_cnt_reg;
      first_next     = first_reg;
      range_err_next = range_err_reg;
      word_cnt_next  = word_cnt_reg;
      addr_load      = 1'b0;
      addr_inc       = 1'b0;

      case (state_reg)
         IDLE, DONE: begin
            if (start_ok) begin
               if (bus.start_addr > bus.end_addr) begin
                  range_err_next = 1'b1;
                  state_next     = IDLE;
               end else begin
                  addr_load      = 1'b1;
                  word_cnt_next  = '0;
                  range_err_next = 1'b0;
                  first_next     = 1'b1;
                  state_next     = FETCH;
               end
            end
         end
         FETCH: begin
            if (MEM_LAT == 0) begin
               state_next = PROCESS;
            end else begin
               wait_cnt_next = WAIT_LOAD;
               state_next    = WAIT;
            end
         end
         WAIT: begin
            if (wait_cnt_reg == '0) begin
               state_next = PROCESS;
            end else begin
               wait_cnt_next = wait_cnt_reg - CRC_WAIT_W'(1);
            end
         end
         PROCESS: begin
            // Holding keeps the address frozen; the memory port keeps its data steady.
            if (consume) begin
               word_cnt_next = word_cnt_reg + (ADDR_W + 1)'(1);
               first_next    = 1'b0;
               if (is_last) begin
                  state_next = DONE;
               end else begin
                  addr_inc   = 1'b1;
                  state_next = FETCH;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Abort overrides everything, including a start presented in the same cycle.
      if (bus.crc_abort) begin
         state_next     = IDLE;
         addr_load      = 1'b0;
         addr_inc       = 1'b0;
         word_cnt_next  = word_cnt_reg;
         first_next     = first_reg;
         range_err_next = range_err_reg;
      end
   end

   assign bus.mem_addr_out = cur_addr;
   assign bus.mem_rd_en    = (state_reg == FETCH);
   assign bus.crc_init     = (state_reg == FETCH) && first_reg;
   assign bus.crc_en       = consume;
   assign bus.crc_last     = consume && is_last;
   assign bus.crc_busy     = scan_active(state_reg);
   assign bus.crc_rdy      = (state_reg == DONE);
   assign bus.range_err    = range_err_reg;
   assign bus.word_cnt     = word_cnt_reg;

endmodule

// File: doc/crc_scan_ctrl.md
Name: crc_scan_ctrl

Overview:
Parametrised sequencer that walks a programmable address window of the CRC source memory and paces the CRC calculator one word at a time. It replaces the fixed 1024-word scan with these additions:
- runtime start/end addresses
- configurable memory read latency
- calculator back-pressure
- abort, range error and word count
It sits between the memory read port and the CRC calculator/compare logic, all in the clk50m domain.

Parameters:
ADDR_W, 10, memory address width; window limited to 0 .. 2^ADDR_W-1
MEM_LAT, 1, read-data latency in cycles after mem_rd_en; range 0..15

Ports:
clk50m  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
crc_start  in  1  pulse; request a scan, sampled in IDLE/DONE only
crc_abort  in  1  synchronous abort; returns to IDLE from any state
start_addr  in  ADDR_W  first address of window, latched on accepted start
end_addr  in  ADDR_W  last address of window (inclusive), latched on accepted start
crc_hold  in  1  calculator back-pressure; 1 = cannot accept a word this cycle
mem_addr_out  out  ADDR_W  current memory address (registered)
mem_rd_en  out  1  one-cycle read strobe per word
crc_init  out  1  one-cycle pulse; calculator clears to seed before first word
crc_en  out  1  one-cycle strobe; memory data valid, calculator consumes it
crc_last  out  1  qualifies crc_en on the final word of the window
crc_busy  out  1  high from accepted start until DONE/IDLE entered
crc_rdy  out  1  level; scan completed, held in DONE until next accepted start
range_err  out  1  level; last start rejected (start_addr > end_addr)
word_cnt  out  ADDR_W+1  words consumed in current/last scan

Behaviour:
- Reset: state IDLE; every output 0, mem_addr_out 0, word_cnt 0; latched addresses 0.
- State enum: IDLE, FETCH, WAIT, PROCESS, DONE. Moore decode for all strobes; mem_addr_out and word_cnt are registers.
- Start acceptance (IDLE or DONE, crc_start=1, crc_abort=0):
  - start_addr > end_addr: range_err<=1, crc_rdy<=0, stay/return IDLE, nothing else changes.
  - Otherwise latch both addresses, mem_addr_out<=start_addr, word_cnt<=0, crc_rdy<=0, range_err<=0, first-word flag<=1, next FETCH.
- crc_start in FETCH/WAIT/PROCESS is ignored.
- FETCH (1 cycle): mem_rd_en=1, crc_busy=1, crc_init=first-word flag.
  - MEM_LAT=0: next PROCESS.
  - Otherwise load wait counter with MEM_LAT-1, next WAIT.
- WAIT: decrement wait counter; at 0 go to PROCESS. Occupies exactly MEM_LAT cycles.
- PROCESS:
  - crc_en = !crc_hold; crc_last = crc_en && (mem_addr_out == end_addr).
  - crc_hold=1: remain in PROCESS, address frozen. Memory data must be stable; the memory read port holds output.
  - On consume: word_cnt+1, first-word flag<=0.
    - Last word: next DONE.
    - Otherwise mem_addr_out+1, next FETCH.
- Throughput without hold: one word per 2+MEM_LAT cycles (3 at default).
- Address arithmetic: ADDR_W bits, equality end test only. end_addr = 2^ADDR_W-1 terminates without wrap; the incrementer is never applied after the last word.
- word_cnt: full window 0..2^ADDR_W-1 gives 2^ADDR_W, hence the ADDR_W+1 width. Holds its value in DONE and IDLE until the next accepted start.
- DONE: crc_rdy=1, crc_busy=0. Accepted start re-runs directly from DONE with FETCH on the next cycle.
- crc_abort=1 in any state: next IDLE, crc_rdy<=0, no crc_en/crc_last that cycle, word_cnt retains partial count. Abort wins over a simultaneous start.
- Asynchronous reset mid-scan: immediate return to reset values. No strobe may be emitted in the reset-release cycle.
- start_addr == end_addr: single word; crc_init, crc_en and crc_last occur in one scan.

Decomposition:
- Package crc_pkg:
  - typedef enum logic [2:0] crc_scan_state_t
  - localparam CRC_WAIT_W = 4 (wait counter width)
  - later shared with crc_calc/compare
- Sub-module crc_addr_cnt: loadable ADDR_W address counter with load, inc, and an is_last compare against the latched end address. The FSM instantiates it once.

Test Plan:
- Defaults, start 0x000, end 0x3FF, no hold: 1024 crc_en, crc_last only at 0x3FF, crc_rdy after 3072+ cycles, word_cnt=1024.
- MEM_LAT=3, window 0x010..0x013: strobes 5 cycles apart, addresses 0x010..0x013, crc_init with first FETCH only, word_cnt=4.
- Window 0x005..0x007, crc_hold high 4 cycles at word 0x006: crc_en delayed 4 cycles, address frozen at 0x006, exactly 3 crc_en total.
- start 0x020, end 0x01F: range_err=1, crc_busy never 1, no mem_rd_en; a following valid start clears range_err.
- Abort during WAIT of word 5 in window 0..9: IDLE next cycle, crc_rdy=0, word_cnt=5. Simultaneous start+abort in IDLE: stays IDLE.
- Single-word window 0x3FF..0x3FF at ADDR_W=10, then restart from DONE: one crc_en with crc_last, no wrap to 0, second run identical.
